// File: rtl/alu_multicycle_unit.sv
// rtl/alu_multicycle_unit.sv - handshaked ALU; shifts iterate one bit per cycle
module alu_multicycle_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   control,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic         overflow,
   output logic         zero,
   output logic         equal
);

   localparam logic [3:0] OP_AND  = 4'b0001;
   localparam logic [3:0] OP_OR   = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_ADD  = 4'b1000;
   localparam logic [3:0] OP_SUB  = 4'b1100;
   localparam logic [3:0] OP_SLT  = 4'b1101;
   localparam logic [3:0] OP_SLTU = 4'b1111;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t       state, state_nxt;
   logic [N-1:0] op_a, op_b, work;
   logic [3:0]   op_ctl;
   logic [4:0]   count;
   logic         accept;
   logic         ctl_is_shift;
   logic [N-1:0] sum, diff, res_c;
   logic         ov_c;

   // in_ready is forced low while reset is held, independent of state
   assign in_ready     = rst && ((state == IDLE) || ((state == DONE) && out_ready));
   assign accept       = in_valid && in_ready;
   assign out_valid    = (state == DONE);
   assign ctl_is_shift = (control == OP_SLL) || (control == OP_SRL) || (control == OP_SRA);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = BUSY;
         BUSY:    if (count == 5'd0) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign sum  = op_a + op_b;
   assign diff = op_a - op_b;

   always_comb begin
      res_c = '0;
      ov_c  = 1'b0;
      case (op_ctl)
         OP_AND:  res_c = op_a & op_b;
         OP_OR:   res_c = op_a | op_b;
         OP_XOR:  res_c = op_a ^ op_b;
         OP_SLL,
         OP_SRL,
         OP_SRA:  res_c = work;
         OP_ADD: begin
            res_c = sum;
            ov_c  = (op_a[N-1] == op_b[N-1]) && (sum[N-1] != op_a[N-1]);
         end
         OP_SUB: begin
            res_c = diff;
            ov_c  = (op_a[N-1] != op_b[N-1]) && (diff[N-1] != op_a[N-1]);
         end
         OP_SLT:  res_c = {{(N-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         OP_SLTU: res_c = {{(N-1){1'b0}}, op_a < op_b};
         default: res_c = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         op_a     <= '0;
         op_b     <= '0;
         op_ctl   <= '0;
         work     <= '0;
         count    <= '0;
         result   <= '0;
         overflow <= 1'b0;
         zero     <= 1'b0;
         equal    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_a   <= a;
            op_b   <= b;
            op_ctl <= control;
            work   <= a;
            count  <= ctl_is_shift ? b[4:0] : 5'd0;
         end else if (state == BUSY) begin
            if (count != 5'd0) begin
               case (op_ctl)
                  OP_SLL:  work <= {work[N-2:0], 1'b0};
                  OP_SRL:  work <= {1'b0, work[N-1:1]};
                  default: work <= {work[N-1], work[N-1:1]};
               endcase
               count <= count - 5'd1;
            end else begin
               result   <= res_c;
               overflow <= ov_c;
               zero     <= (res_c == '0);
               equal    <= (op_a == op_b);
            end
         end
      end
   end

endmodule

// File: doc/alu_multicycle_unit.md
Name: alu_multicycle_unit

Overview:
- Handshaked, sequential execution unit. It is the responder on the operand/control interface that the ALU benches drive.
- Accepts one (a, b, control) request through a valid/ready handshake and computes the result.
- Shift operations iterate one bit position per cycle; all other operations finish in one cycle.
- Returns result plus overflow/zero/equal flags through a second valid/ready handshake. It sits between the register-read stage and the writeback of the multicycle core.

Parameters:
- N, 32, datapath width. Only 32 is supported; shift amount is b[4:0].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request this cycle
- a  input  N  operand A
- b  input  N  operand B; b[4:0] is the shift amount for shifts
- control  input  alu_control_t (4)  operation select
- out_valid  output  1  response valid
- out_ready  input  1  consumer accepts response
- result  output  N  operation result
- overflow  output  1  signed overflow, ADD/SUB only
- zero  output  1  result == 0
- equal  output  1  captured a == captured b

Behaviour:
- Encodings, fixed in alu_types.sv:
  - AND 0001, OR 0010, XOR 0011
  - SLL 0101, SRL 0110, SRA 0111
  - ADD 1000, SUB 1100, SLT 1101, SLTU 1111
  - Every other code is illegal.
- Reset (rst=0, asynchronous): state IDLE; in_ready=0 while rst=0; out_valid=0; result=0; overflow=0; zero=0; equal=0; internal count=0.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept: in_valid && in_ready on a rising edge (E0).
  - Capture a, b and control.
  - count = b[4:0] for SLL/SRL/SRA, else 0.
  - Work register = a.
  - Next state BUSY.
  - Inputs are ignored when they are not accepted.
- BUSY, count != 0: each edge shifts the work register by 1 and decrements count.
  - SLL shifts in 0 at the LSB.
  - SRL shifts in 0 at the MSB.
  - SRA replicates bit N-1.
- BUSY, count == 0: next edge registers result and flags, sets out_valid=1, and moves to DONE.
- Latency: out_valid is first high after edge E0+1+s, where s is the shift amount (0 for non-shift ops).
  - Non-shift op: 1 cycle.
  - SLL by 31: 32 cycles.
- Results:
  - ADD: a+b mod 2^N; overflow = (a[31]==b[31]) && (sum[31]!=a[31]).
  - SUB: a-b mod 2^N; overflow = (a[31]!=b[31]) && (diff[31]!=a[31]).
  - SLT: signed a<b gives 1, else 0; overflow=0.
  - SLTU: unsigned a<b gives 1, else 0; overflow=0.
  - AND/OR/XOR: bitwise; overflow=0.
  - Shifts: final work register; overflow=0.
  - Illegal code: result=0, overflow=0, 1-cycle latency. It never hangs.
- zero = (result==0), registered with result. equal is computed from the captured operands for every op.
- DONE:
  - result and all flags are held stable while out_valid && !out_ready.
  - out_valid && out_ready with no new request: out_valid drops and the state goes to IDLE.
  - out_valid && out_ready with in_valid: the new request is accepted on the same edge (state goes to BUSY), out_valid drops, and there is no bubble.
- Output registers keep their last values after handoff; consumers qualify them with out_valid.
- Reset mid-operation (BUSY or DONE): the pending operation is discarded with no partial response; all outputs return to reset values immediately.
- Shift amount uses b[4:0] only; b[31:5] is ignored.

Test Plan:
- Reset mid-op: assert rst=0 during BUSY of SLL a=1, b=31 -> out_valid=0 immediately. After release, in_ready=1 and no response for the discarded op is ever produced.
- ADD a=7FFFFFFF, b=00000001 -> one cycle after accept: result=80000000, overflow=1, zero=0, equal=0. SUB a=b=12345678 -> result=0, zero=1, equal=1, overflow=0.
- SRA a=80000000, b=0000001F -> out_valid after exactly 32 cycles, result=FFFFFFFF. SRL with same operands -> result=00000001. SLL a=1, b=FFFFFFE0 (amount 0) -> 1 cycle, result=00000001.
- Backpressure: SLT a=FFFFFFFF, b=00000001 completes (result=1); hold out_ready=0 for 5 cycles -> out_valid and result stable and in_ready=0. SLTU with the same operands afterwards gives result=0.
- Back-to-back: in the DONE cycle, set out_ready=1 and in_valid=1 with XOR a=F0F0F0F0, b=0F0F0F0F -> new request accepted on the same edge; next response result=FFFFFFFF.
- Illegal control 0000 with a=5, b=5 -> 1 cycle latency, result=0, zero=1, equal=1, overflow=0. Follow with 25 random legal ops checked against the behavioural ALU model.
